// File: rtl/debug_line_framer_pkg.sv
// rtl/debug_line_framer_pkg.sv - shared constants, FSM state type and hex helper for debug_line_framer (honours DEBUG_LINE_SEQ_EN)
package debug_pkg;

  localparam logic [7:0] ASCII_EQ = 8'h3D;
  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;
  localparam logic [7:0] ASCII_0  = 8'h30;
  localparam logic [7:0] ASCII_A  = 8'h41;

  // Bytes in a line that are not data hex digits: prefix, '=', CR, LF (+ two sequence digits).
`ifdef DEBUG_LINE_SEQ_EN
  localparam int LINE_FIXED_BYTES = 6;
`else
  localparam int LINE_FIXED_BYTES = 4;
`endif

  typedef enum logic [2:0] {
    IDLE,
    PREFIX,
    SEQ,
    EQ,
    HEX,
    CR,
    LF
  } state_e;

  function automatic logic [7:0] nibble_to_ascii(input logic [3:0] n);
    if (n < 4'd10) return ASCII_0 + {4'h0, n};
    return ASCII_A + {4'h0, n} - 8'd10;
  endfunction

  function automatic int line_len(input int n_digits);
    return LINE_FIXED_BYTES + n_digits;
  endfunction

endpackage

// File: rtl/debug_line_framer_if.sv
// rtl/debug_line_framer_if.sv - trigger capture and UART write port bundle for debug_line_framer
interface debug_line_framer_if #(
  parameter int DATA_W = 4
);
  logic              trigger;
  logic [DATA_W-1:0] data;
  logic              tx_full;
  logic              wr_uart;
  logic [7:0]        w_data;
  logic              busy;
  logic [7:0]        drop_cnt;

  modport master (
    output trigger, data, tx_full,
    input  wr_uart, w_data, busy, drop_cnt
  );

  modport slave (
    input  trigger, data, tx_full,
    output wr_uart, w_data, busy, drop_cnt
  );
endinterface

// File: rtl/debug_line_framer_event_fifo.sv
// rtl/debug_line_framer_event_fifo.sv - dbg_event_fifo: small synchronous FIFO with simultaneous push/pop
module dbg_event_fifo #(
  parameter int WIDTH = 4,
  parameter int AW    = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int DEPTH = 1 << AW;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;

  // Storage array needs no reset; validity is tracked by count_q.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  // Pointers and occupancy; caller never pushes when full without a matching pop.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_i)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push_i, pop_i})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);

endmodule

// File: rtl/debug_line_framer.sv
// rtl/debug_line_framer.sv - formats debugger events as "D=<hex>\r\n" lines to a UART write port; DEBUG_LINE_SEQ_EN adds a sequence field
module debug_line_framer
  import debug_pkg::*;
#(
  parameter int         DATA_W      = 4,
  parameter int         FIFO_AW     = 2,
  parameter logic [7:0] PREFIX_CHAR = 8'h44
) (
  input logic                 clk,
  input logic                 reset,
  debug_line_framer_if.slave  bus
);
  localparam int N     = DATA_W / 4;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
`ifdef DEBUG_LINE_SEQ_EN
  localparam int FW = DATA_W + 8;
`else
  localparam int FW = DATA_W;
`endif

  logic          fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [FW-1:0] fifo_wdata, fifo_rdata;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] line_q, line_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [7:0]        last_q;
  logic [7:0]        drop_q;
  logic [7:0]        cur_byte;
  logic              wr;
`ifdef DEBUG_LINE_SEQ_EN
  logic [7:0]        seq_cnt_q;
  logic [7:0]        seq_line_q, seq_line_d;
`endif

  // A pop frees a slot in the same cycle, so a trigger on a full FIFO is still accepted then.
  assign fifo_pop  = (state_q == IDLE) & ~fifo_empty;
  assign fifo_push = bus.trigger & (~fifo_full | fifo_pop);
`ifdef DEBUG_LINE_SEQ_EN
  assign fifo_wdata = {seq_cnt_q, bus.data};
`else
  assign fifo_wdata = bus.data;
`endif

  dbg_event_fifo #(.WIDTH(FW), .AW(FIFO_AW)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (fifo_push),
    .wdata_i (fifo_wdata),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Saturating count of triggers that found no room.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) drop_q <= '0;
    else if (bus.trigger && !fifo_push && drop_q != 8'hFF) drop_q <= drop_q + 8'd1;
  end

`ifdef DEBUG_LINE_SEQ_EN
  // Sequence number advances only for accepted events and wraps naturally.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) seq_cnt_q <= '0;
    else if (fifo_push) seq_cnt_q <= seq_cnt_q + 8'd1;
  end
`endif

  // Byte for the current state; in IDLE the last emitted byte is held.
  always_comb begin
    cur_byte = last_q;
    case (state_q)
      PREFIX:  cur_byte = PREFIX_CHAR;
`ifdef DEBUG_LINE_SEQ_EN
      SEQ:     cur_byte = nibble_to_ascii(seq_line_q[7:4]);
`endif
      EQ:      cur_byte = ASCII_EQ;
      HEX:     cur_byte = nibble_to_ascii(line_q[DATA_W-1 -: 4]);
      CR:      cur_byte = ASCII_CR;
      LF:      cur_byte = ASCII_LF;
      default: cur_byte = last_q;
    endcase
  end

  assign wr           = (state_q != IDLE) & ~bus.tx_full;
  assign bus.wr_uart  = wr;
  assign bus.w_data   = cur_byte;
  assign bus.busy     = (state_q != IDLE) | ~fifo_empty;
  assign bus.drop_cnt = drop_q;

  // Next state: advance only on an accepted byte; digits shift out MSB-first.
  always_comb begin
    state_d = state_q;
    line_d  = line_q;
    cnt_d   = cnt_q;
`ifdef DEBUG_LINE_SEQ_EN
    seq_line_d = seq_line_q;
`endif
    case (state_q)
      IDLE: if (fifo_pop) begin
        state_d = PREFIX;
        line_d  = fifo_rdata[DATA_W-1:0];
`ifdef DEBUG_LINE_SEQ_EN
        seq_line_d = fifo_rdata[FW-1 -: 8];
`endif
      end
      PREFIX: if (wr) begin
`ifdef DEBUG_LINE_SEQ_EN
        state_d = SEQ;
        cnt_d   = CNT_W'(1);
`else
        state_d = EQ;
`endif
      end
`ifdef DEBUG_LINE_SEQ_EN
      SEQ: if (wr) begin
        seq_line_d = {seq_line_q[3:0], 4'h0};
        if (cnt_q == '0) state_d = EQ;
        else cnt_d = cnt_q - CNT_W'(1);
      end
`endif
      EQ: if (wr) begin
        state_d = HEX;
        cnt_d   = CNT_W'(N - 1);
      end
      HEX: if (wr) begin
        line_d = line_q << 4;
        if (cnt_q == '0) state_d = CR;
        else cnt_d = cnt_q - CNT_W'(1);
      end
      CR:      if (wr) state_d = LF;
      LF:      if (wr) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Line state register; reset abandons any line in progress.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      line_q  <= '0;
      cnt_q   <= '0;
      last_q  <= '0;
`ifdef DEBUG_LINE_SEQ_EN
      seq_line_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      line_q  <= line_d;
      cnt_q   <= cnt_d;
      if (wr) last_q <= cur_byte;
`ifdef DEBUG_LINE_SEQ_EN
      seq_line_q <= seq_line_d;
`endif
    end
  end

endmodule

// File: tb/tb_debug_line_framer.sv
// tb/tb_debug_line_framer.sv - self-checking bench for debug_line_framer (default build and DEBUG_LINE_SEQ_EN)
module tb_debug_line_framer;
  localparam int DATA_W  = 4;
  localparam int FIFO_AW = 2;
  localparam int DEPTH   = 1 << FIFO_AW;
  localparam int N       = DATA_W / 4;
`ifdef DEBUG_LINE_SEQ_EN
  localparam int LLEN = 6 + N;
`else
  localparam int LLEN = 4 + N;
`endif
  localparam int PRE = LLEN - N - 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  debug_line_framer_if #(.DATA_W(DATA_W)) bus();

  debug_line_framer #(
    .DATA_W      (DATA_W),
    .FIFO_AW     (FIFO_AW),
    .PREFIX_CHAR (8'h44)
  ) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;

  logic [7:0] exp_q[$];
  int         m_cnt;
  int         m_rem;
  int         m_drop;
  logic [7:0] m_seq;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    if (n < 4'd10) return 8'h30 + {4'h0, n};
    return 8'h37 + {4'h0, n};
  endfunction

  task automatic queue_line(input logic [DATA_W-1:0] d);
    exp_q.push_back(8'h44);
`ifdef DEBUG_LINE_SEQ_EN
    exp_q.push_back(hex_char(m_seq[7:4]));
    exp_q.push_back(hex_char(m_seq[3:0]));
    m_seq = m_seq + 8'd1;
`endif
    exp_q.push_back(8'h3D);
    for (int i = N - 1; i >= 0; i--) exp_q.push_back(hex_char(d[i*4 +: 4]));
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
  endtask

  task automatic reset_model();
    m_cnt  = 0;
    m_rem  = 0;
    m_drop = 0;
    m_seq  = 8'h00;
    exp_q.delete();
  endtask

  // One clock cycle: drive inputs, check outputs mid-cycle against the model, then advance.
  task automatic cyc(input logic trig, input logic [DATA_W-1:0] d, input logic full);
    logic exp_wr, pop, push;
    bus.trigger = trig;
    bus.data    = d;
    bus.tx_full = full;
    @(negedge clk);
    exp_wr = (m_rem > 0) && !full;
    pop    = (m_rem == 0) && (m_cnt > 0);
    push   = trig && ((m_cnt < DEPTH) || pop);
    chk("wr_uart", bus.wr_uart, exp_wr);
    chk("busy", bus.busy, (m_rem > 0) || (m_cnt > 0));
    if (bus.wr_uart === 1'b1) begin
      chk("byte_expected", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) chk("w_data", bus.w_data, exp_q.pop_front());
    end
    if (exp_wr) m_rem--;
    if (pop) begin
      m_rem = LLEN;
      m_cnt--;
    end
    if (push) begin
      m_cnt++;
      queue_line(d);
    end
    if (trig && !push && m_drop < 255) m_drop++;
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int bound);
    int k = 0;
    while ((m_rem > 0 || m_cnt > 0) && k < bound) begin
      cyc(1'b0, '0, 1'b0);
      k++;
    end
    chk("drain_in_time", (m_rem == 0 && m_cnt == 0), 1);
    cyc(1'b0, '0, 1'b0);
    chk("all_bytes_seen", exp_q.size(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.trigger = 1'b0;
    bus.data    = '0;
    bus.tx_full = 1'b0;
    reset_model();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_wr_uart", bus.wr_uart, 0);
    chk("rst_w_data", bus.w_data, 8'h00);
    chk("rst_busy", bus.busy, 0);
    chk("rst_drop_cnt", bus.drop_cnt, 8'h00);
    rst_n = 1'b1;
    cyc(1'b0, '0, 1'b0);

    // Single event 'A'
    cyc(1'b1, 4'hA, 1'b0);
    drain(40);

    // Backpressure during the hex digit
    cyc(1'b1, 4'hA, 1'b0);
    repeat (1 + PRE) cyc(1'b0, '0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      cyc(1'b0, '0, 1'b1);
      chk("stall_w_data", bus.w_data, 8'h41);
    end
    drain(40);

    // Burst of four back-to-back triggers
    for (int i = 1; i <= 4; i++) cyc(1'b1, DATA_W'(i), 1'b0);
    drain(80);
    chk("burst_drop_cnt", bus.drop_cnt, 8'h00);

    // Six triggers while the first line is stalled
    for (int i = 0; i < 6; i++) cyc(1'b1, DATA_W'(i + 5), 1'b1);
    chk("ovf_drop_cnt", bus.drop_cnt, m_drop);
    drain(120);

    // Saturation of the drop counter
    for (int i = 0; i < 300; i++) cyc(1'b1, DATA_W'(i), 1'b1);
    chk("sat_drop_cnt", bus.drop_cnt, 8'hFF);
    chk("sat_drop_model", bus.drop_cnt, m_drop);
    drain(200);

    // Reset in the middle of the hex digit
    cyc(1'b1, 4'h7, 1'b0);
    repeat (1 + PRE) cyc(1'b0, '0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_wr_uart", bus.wr_uart, 0);
    chk("midrst_w_data", bus.w_data, 8'h00);
    chk("midrst_busy", bus.busy, 0);
    chk("midrst_drop_cnt", bus.drop_cnt, 8'h00);
    reset_model();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) cyc(1'b0, '0, 1'b0);
    cyc(1'b1, 4'hC, 1'b0);
    drain(40);

    // Random traffic with random backpressure
    for (int i = 0; i < 60; i++)
      cyc(($urandom % 4) == 0, DATA_W'($urandom), ($urandom % 3) == 0);
    drain(200);
    chk("rand_drop_cnt", bus.drop_cnt, m_drop);

`ifdef DEBUG_LINE_SEQ_EN
    // Sequence wrap across 257 lines
    reset_model();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int e = 0; e < 257; e++) begin
      cyc(1'b1, DATA_W'(e), 1'b0);
      repeat (LLEN) cyc(1'b0, '0, 1'b0);
    end
    drain(40);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
